step_grid_renderer: RTL and testbench

- Parametrised pixel-plot engine for the sequencer display: draws an NUM_ROWS x NUM_COLS grid of CELL x CELL step cells, plus a 10-point glyph label per row, into the VGA adapter's plot interface.
- Generalises the fixed 4x16, 3x3 renderer with:
  - configurable geometry;
  - a start/busy/done frame handshake;
  - input snapshotting, so a frame never tears;
  - an optional free-running mode.
- Sits between the sequencer core (pattern, beat, selected row) and the VGA adapter.

---
 rtl/step_grid_renderer_if.sv | 39 +++
 rtl/step_grid_renderer.sv | 250 +++++++++++++++++++++++++
 tb/tb_step_grid_renderer.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/step_grid_renderer_if.sv
// step_grid_renderer_if
// Groups the frame handshake, the snapshot inputs and the pixel-plot outputs
// of the step grid renderer into one bundle.
//   master : the sequencer side. Drives start/autoRun, origin, pattern, beat
//            and select. Observes xOut/yOut/cOut/plot/busy/done.
//   slave  : the renderer side. Observes the inputs and drives the plot
//            outputs.
// NUM_ROWS/NUM_COLS/ROW_W/COL_W must match the renderer instance the bundle
// is connected to.
interface step_grid_renderer_if #(
    parameter int NUM_ROWS = 4,
    parameter int NUM_COLS = 16,
    parameter int ROW_W    = 2,
    parameter int COL_W    = 4
);
    logic                         start;
    logic                         autoRun;
    logic [7:0]                   xOrigin;
    logic [6:0]                   yOrigin;
    logic [NUM_ROWS*NUM_COLS-1:0] pattern;
    logic [COL_W-1:0]             beat;
    logic [ROW_W-1:0]             select;
    logic [7:0]                   xOut;
    logic [6:0]                   yOut;
    logic [2:0]                   cOut;
    logic                         plot;
    logic                         busy;
    logic                         done;

    modport master (
        output start, autoRun, xOrigin, yOrigin, pattern, beat, select,
        input  xOut, yOut, cOut, plot, busy, done
    );

    modport slave (
        input  start, autoRun, xOrigin, yOrigin, pattern, beat, select,
        output xOut, yOut, cOut, plot, busy, done
    );
endinterface

// File: rtl/step_grid_renderer.sv
// step_grid_renderer
// Pixel-plot engine for the sequencer display. It draws one frame of
// NUM_ROWS rows. Each row is a 10-point glyph label followed by NUM_COLS step
// cells of CELL x CELL pixels. Pixels are written one per cycle into the VGA
// adapter's plot interface.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : step_grid_renderer_if.slave
//           inputs : start, autoRun, xOrigin, yOrigin, pattern, beat, select
//           outputs: xOut, yOut, cOut, plot, busy, done
// All outputs are registered. Pixel k of a frame appears k+1 cycles after
// the edge that accepted the frame.
module step_grid_renderer #(
    parameter int NUM_ROWS  = 4,
    parameter int NUM_COLS  = 16,
    parameter int CELL      = 3,
    parameter int COL_PITCH = 8,
    parameter int ROW_PITCH = 20,
    parameter int LABEL_X   = 5,
    parameter int ROW_W     = 2,
    parameter int COL_W     = 4
) (
    input logic                 clk,
    input logic                 reset,
    step_grid_renderer_if.slave bus
);

    typedef enum logic [1:0] {IDLE, LABEL, CELLS, DONE} state_t;

    // Glyph point tables. Point p sits at bit p*2 (x) or p*3 (y), with point 0
    // in the least significant bits.
    localparam logic [19:0] GX_A = {2'd2, 2'd0, 2'd2, 2'd0, 2'd2, 2'd1, 2'd0, 2'd2, 2'd0, 2'd1};
    localparam logic [29:0] GY_A = {3'd4, 3'd4, 3'd3, 3'd3, 3'd2, 3'd2, 3'd2, 3'd1, 3'd1, 3'd0};
    localparam logic [19:0] GX_C = {2'd3, 2'd3, 2'd2, 2'd1, 2'd0, 2'd0, 2'd0, 2'd3, 2'd2, 2'd1};
    localparam logic [29:0] GY_C = {3'd3, 3'd4, 3'd4, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd0};
    localparam logic [19:0] GX_D = {2'd1, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0};
    localparam logic [29:0] GY_D = {3'd4, 3'd4, 3'd3, 3'd3, 3'd2, 3'd2, 3'd1, 3'd1, 3'd0, 3'd0};
    localparam logic [19:0] GX_F = {2'd0, 2'd0, 2'd2, 2'd1, 2'd0, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0};
    localparam logic [29:0] GY_F = {3'd4, 3'd3, 3'd2, 3'd2, 3'd2, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0};

    state_t state_q, state_d;

    logic [2:0] row_q, row_d;
    logic [3:0] pt_q,  pt_d;
    logic [3:0] col_q, col_d;
    logic [2:0] px_q,  px_d;
    logic [2:0] py_q,  py_d;

    logic [NUM_ROWS*NUM_COLS-1:0] pattern_q, pattern_d;
    logic [COL_W-1:0]             beat_q,    beat_d;
    logic [ROW_W-1:0]             select_q,  select_d;
    logic [7:0]                   xOrg_q,    xOrg_d;
    logic [6:0]                   yOrg_q,    yOrg_d;

    logic [7:0] xOut_q, xOut_d;
    logic [6:0] yOut_q, yOut_d;
    logic [2:0] cOut_q, cOut_d;
    logic       plot_q, plot_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic [19:0]  gxTab;
    logic [29:0]  gyTab;
    logic [4:0]   gxIdx;
    logic [4:0]   gyIdx;
    logic [1:0]   gx;
    logic [2:0]   gy;
    logic [15:0]  rowBaseY;
    logic [127:0] patFull;
    logic [6:0]   patIdx;
    logic         patBit;
    logic         isSel;
    logic         isBeat;
    logic         interior;

    // Frame sequencing. Counters walk label points, then the cells of the same
    // row (column outer, py middle, px inner). Then they move to the next row
    // or finish. The snapshot registers load only on the edge that accepts a
    // frame, so later input changes cannot tear the frame being drawn.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        pt_d      = pt_q;
        col_d     = col_q;
        px_d      = px_q;
        py_d      = py_q;
        pattern_d = pattern_q;
        beat_d    = beat_q;
        select_d  = select_q;
        xOrg_d    = xOrg_q;
        yOrg_d    = yOrg_q;
        case (state_q)
            IDLE: begin
                if (bus.start || bus.autoRun) begin
                    state_d   = LABEL;
                    row_d     = '0;
                    pt_d      = '0;
                    col_d     = '0;
                    px_d      = '0;
                    py_d      = '0;
                    pattern_d = bus.pattern;
                    beat_d    = bus.beat;
                    select_d  = bus.select;
                    xOrg_d    = bus.xOrigin;
                    yOrg_d    = bus.yOrigin;
                end
            end
            LABEL: begin
                if (pt_q == 4'd9) begin
                    pt_d    = '0;
                    state_d = CELLS;
                end else begin
                    pt_d = pt_q + 4'd1;
                end
            end
            CELLS: begin
                if (px_q == 3'(CELL - 1)) begin
                    px_d = '0;
                    if (py_q == 3'(CELL - 1)) begin
                        py_d = '0;
                        if (col_q == 4'(NUM_COLS - 1)) begin
                            col_d = '0;
                            if (row_q == 3'(NUM_ROWS - 1)) begin
                                row_d   = '0;
                                state_d = DONE;
                            end else begin
                                row_d   = row_q + 3'd1;
                                state_d = LABEL;
                            end
                        end else begin
                            col_d = col_q + 4'd1;
                        end
                    end else begin
                        py_d = py_q + 3'd1;
                    end
                end else begin
                    px_d = px_q + 3'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pixel datapath. Coordinates are computed at 16 bits and then truncated.
    // This gives the silent mod-256 / mod-128 wrap with no clipping. Outside
    // the drawing states the coordinate and colour registers hold their values.
    always_comb begin
        case (row_q[1:0])
            2'd0:    begin gxTab = GX_A; gyTab = GY_A; end
            2'd1:    begin gxTab = GX_C; gyTab = GY_C; end
            2'd2:    begin gxTab = GX_D; gyTab = GY_D; end
            default: begin gxTab = GX_F; gyTab = GY_F; end
        endcase
        gxIdx    = {pt_q, 1'b0};
        gyIdx    = {1'b0, pt_q} + {pt_q, 1'b0};
        gx       = gxTab[gxIdx +: 2];
        gy       = gyTab[gyIdx +: 3];
        rowBaseY = 16'(yOrg_q) + 16'(row_q) * 16'(ROW_PITCH);
        patFull  = 128'(pattern_q);
        patIdx   = 7'(row_q) * 7'(NUM_COLS) + 7'(col_q);
        patBit   = patFull[patIdx];
        isSel    = (row_q == 3'(select_q));
        isBeat   = (col_q == 4'(beat_q));
        interior = (px_q != 3'd0) && (px_q != 3'(CELL - 1)) &&
                   (py_q != 3'd0) && (py_q != 3'(CELL - 1));

        xOut_d = xOut_q;
        yOut_d = yOut_q;
        cOut_d = cOut_q;
        plot_d = 1'b0;
        done_d = (state_q == DONE);
        busy_d = (state_q != IDLE);
        case (state_q)
            LABEL: begin
                xOut_d = 8'(16'(LABEL_X) + 16'(gx));
                yOut_d = 7'(rowBaseY + 16'(gy));
                cOut_d = isSel ? 3'b100 : 3'b111;
                plot_d = 1'b1;
            end
            CELLS: begin
                xOut_d = 8'(16'(xOrg_q) + 16'(col_q) * 16'(COL_PITCH) + 16'(px_q));
                yOut_d = 7'(rowBaseY + 16'(py_q));
                if (interior) begin
                    cOut_d = patBit ? 3'b001 : 3'b111;
                end else begin
                    cOut_d = isBeat ? 3'b110 : 3'b000;
                end
                plot_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // State, counters, snapshot and output registers. Reset drops plot/busy
    // immediately, whatever the frame is doing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            row_q     <= '0;
            pt_q      <= '0;
            col_q     <= '0;
            px_q      <= '0;
            py_q      <= '0;
            pattern_q <= '0;
            beat_q    <= '0;
            select_q  <= '0;
            xOrg_q    <= '0;
            yOrg_q    <= '0;
            xOut_q    <= '0;
            yOut_q    <= '0;
            cOut_q    <= '0;
            plot_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            pt_q      <= pt_d;
            col_q     <= col_d;
            px_q      <= px_d;
            py_q      <= py_d;
            pattern_q <= pattern_d;
            beat_q    <= beat_d;
            select_q  <= select_d;
            xOrg_q    <= xOrg_d;
            yOrg_q    <= yOrg_d;
            xOut_q    <= xOut_d;
            yOut_q    <= yOut_d;
            cOut_q    <= cOut_d;
            plot_q    <= plot_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.xOut = xOut_q;
    assign bus.yOut = yOut_q;
    assign bus.cOut = cOut_q;
    assign bus.plot = plot_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_step_grid_renderer.sv
// tb_step_grid_renderer
// Directed bench for step_grid_renderer.
//   dutA : default geometry, 4 rows x 16 columns, 3x3 cells
//   dutB : 2 rows x 8 columns, 4x4 cells, used for free-running frames and
//          coordinate wrap
// Outputs are sampled on the falling edge. Inputs are also changed on the
// falling edge.
module tb_step_grid_renderer;

    logic clk;
    logic resetA;
    logic resetB;

    step_grid_renderer_if #(.NUM_ROWS(4), .NUM_COLS(16), .ROW_W(2), .COL_W(4)) busA ();
    step_grid_renderer_if #(.NUM_ROWS(2), .NUM_COLS(8),  .ROW_W(1), .COL_W(3)) busB ();

    step_grid_renderer dutA (
        .clk   (clk),
        .reset (resetA),
        .bus   (busA)
    );

    step_grid_renderer #(
        .NUM_ROWS (2),
        .NUM_COLS (8),
        .CELL     (4),
        .ROW_W    (1),
        .COL_W    (3)
    ) dutB (
        .clk   (clk),
        .reset (resetB),
        .bus   (busB)
    );

    int checks;
    int failures;

    logic [7:0] xs [0:1023];
    logic [6:0] ys [0:1023];
    logic [2:0] cs [0:1023];
    int nPlots;
    int firstPlot;
    int doneAt;
    logic doneBusy;
    logic afterBusy;
    logic afterPlot;

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Starts one frame on dutA and records every plotted pixel. Sample k is
    // the k-th falling edge after the accepting edge. With perturb set, the
    // inputs are changed and start is pulsed once the 100th pixel is seen.
    task automatic captureFrame(input bit perturb);
        bit fired;
        fired     = 1'b0;
        nPlots    = 0;
        firstPlot = -1;
        doneAt    = -1;
        doneBusy  = 1'b0;
        afterBusy = 1'b1;
        afterPlot = 1'b1;
        busA.start = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 2000; k++) begin
            busA.start = 1'b0;
            if (busA.plot) begin
                if (nPlots < 1024) begin
                    xs[nPlots] = busA.xOut;
                    ys[nPlots] = busA.yOut;
                    cs[nPlots] = busA.cOut;
                end
                if (firstPlot < 0) firstPlot = k;
                nPlots++;
            end
            if (perturb && !fired && nPlots == 100) begin
                fired        = 1'b1;
                busA.pattern = '1;
                busA.beat    = 4'd3;
                busA.select  = 2'd1;
                busA.start   = 1'b1;
            end
            if (busA.done) begin
                doneAt   = k;
                doneBusy = busA.busy;
                @(negedge clk);
                afterBusy = busA.busy;
                afterPlot = busA.plot;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        resetA = 1'b1;
        resetB = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (busA.plot !== 1'b0) begin failures++; $display("[TB] FAIL reset plotA: got %0b, expected 0", busA.plot); end
        checks++; if (busA.busy !== 1'b0) begin failures++; $display("[TB] FAIL reset busyA: got %0b, expected 0", busA.busy); end
        checks++; if (busA.done !== 1'b0) begin failures++; $display("[TB] FAIL reset doneA: got %0b, expected 0", busA.done); end
        checks++; if (busA.xOut !== 8'd0) begin failures++; $display("[TB] FAIL reset xOutA: got %0d, expected 0", busA.xOut); end
        checks++; if (busA.yOut !== 7'd0) begin failures++; $display("[TB] FAIL reset yOutA: got %0d, expected 0", busA.yOut); end
        checks++; if (busA.cOut !== 3'd0) begin failures++; $display("[TB] FAIL reset cOutA: got %0d, expected 0", busA.cOut); end
        checks++; if (busB.busy !== 1'b0) begin failures++; $display("[TB] FAIL reset busyB: got %0b, expected 0", busB.busy); end
        resetA = 1'b0;
        resetB = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busA.plot !== 1'b0) begin failures++; $display("[TB] FAIL idle plotA: got %0b, expected 0", busA.plot); end
        checks++; if (busA.busy !== 1'b0) begin failures++; $display("[TB] FAIL idle busyA: got %0b, expected 0", busA.busy); end
    endtask

    task automatic test_first_frame();
        busA.xOrigin = 8'd20;
        busA.yOrigin = 7'd10;
        busA.select  = 2'd0;
        busA.beat    = 4'd0;
        busA.pattern = '0;
        captureFrame(1'b0);
        checks++; if (firstPlot !== 1) begin failures++; $display("[TB] FAIL t1 latency: got %0d, expected 1", firstPlot); end
        checks++; if (nPlots !== 616) begin failures++; $display("[TB] FAIL t1 plots: got %0d, expected 616", nPlots); end
        checks++; if (doneAt !== 617) begin failures++; $display("[TB] FAIL t1 doneAt: got %0d, expected 617", doneAt); end
        checks++; if (doneBusy !== 1'b1) begin failures++; $display("[TB] FAIL t1 busyInDone: got %0b, expected 1", doneBusy); end
        checks++; if (afterBusy !== 1'b0) begin failures++; $display("[TB] FAIL t1 busyAfter: got %0b, expected 0", afterBusy); end
        checks++; if (afterPlot !== 1'b0) begin failures++; $display("[TB] FAIL t1 plotAfter: got %0b, expected 0", afterPlot); end
        checks++; if (xs[0] !== 8'd6)  begin failures++; $display("[TB] FAIL t1 x0: got %0d, expected 6", xs[0]); end
        checks++; if (ys[0] !== 7'd10) begin failures++; $display("[TB] FAIL t1 y0: got %0d, expected 10", ys[0]); end
        checks++; if (cs[0] !== 3'b100) begin failures++; $display("[TB] FAIL t1 c0: got %0b, expected 100", cs[0]); end
        checks++; if (xs[9] !== 8'd7 || ys[9] !== 7'd14) begin failures++; $display("[TB] FAIL t1 p9: got (%0d,%0d), expected (7,14)", xs[9], ys[9]); end
        checks++; if (xs[10] !== 8'd20 || ys[10] !== 7'd10) begin failures++; $display("[TB] FAIL t1 cell0 xy: got (%0d,%0d), expected (20,10)", xs[10], ys[10]); end
        checks++; if (cs[10] !== 3'b110) begin failures++; $display("[TB] FAIL t1 cell0 c: got %0b, expected 110", cs[10]); end
        checks++; if (cs[14] !== 3'b111) begin failures++; $display("[TB] FAIL t1 interior off c: got %0b, expected 111", cs[14]); end
    endtask

    task automatic test_pattern_colors();
        busA.pattern = '0;
        busA.pattern[1*16+3] = 1'b1;
        busA.beat    = 4'd5;
        busA.select  = 2'd0;
        captureFrame(1'b0);
        checks++; if (nPlots !== 616) begin failures++; $display("[TB] FAIL t2 plots: got %0d, expected 616", nPlots); end
        checks++; if (xs[195] !== 8'd45 || ys[195] !== 7'd31) begin failures++; $display("[TB] FAIL t2 on xy: got (%0d,%0d), expected (45,31)", xs[195], ys[195]); end
        checks++; if (cs[195] !== 3'b001) begin failures++; $display("[TB] FAIL t2 on c: got %0b, expected 001", cs[195]); end
        checks++; if (xs[186] !== 8'd37 || ys[186] !== 7'd31) begin failures++; $display("[TB] FAIL t2 off xy: got (%0d,%0d), expected (37,31)", xs[186], ys[186]); end
        checks++; if (cs[186] !== 3'b111) begin failures++; $display("[TB] FAIL t2 off c: got %0b, expected 111", cs[186]); end
        checks++; if (xs[209] !== 8'd60 || cs[209] !== 3'b110) begin failures++; $display("[TB] FAIL t2 beat border: got x=%0d c=%0b, expected x=60 c=110", xs[209], cs[209]); end
        checks++; if (xs[200] !== 8'd52 || cs[200] !== 3'b000) begin failures++; $display("[TB] FAIL t2 plain border: got x=%0d c=%0b, expected x=52 c=000", xs[200], cs[200]); end
        checks++; if (xs[154] !== 8'd6 || ys[154] !== 7'd30 || cs[154] !== 3'b111) begin failures++; $display("[TB] FAIL t2 row1 label: got (%0d,%0d,%0b), expected (6,30,111)", xs[154], ys[154], cs[154]); end
    endtask

    task automatic test_select_highlight();
        busA.pattern = '0;
        busA.beat    = 4'd0;
        busA.select  = 2'd2;
        captureFrame(1'b0);
        for (int p = 0; p < 10; p++) begin
            checks++; if (cs[308+p] !== 3'b100) begin failures++; $display("[TB] FAIL t3 row2 label c p%0d: got %0b, expected 100", p, cs[308+p]); end
            checks++; if (xs[308+p] < 8'd5 || xs[308+p] > 8'd8 || ys[308+p] < 7'd50 || ys[308+p] > 7'd54) begin
                failures++; $display("[TB] FAIL t3 row2 label xy p%0d: got (%0d,%0d), expected x 5..8 y 50..54", p, xs[308+p], ys[308+p]);
            end
        end
        checks++; if (xs[311] !== 8'd7 || ys[311] !== 7'd51) begin failures++; $display("[TB] FAIL t3 D p3: got (%0d,%0d), expected (7,51)", xs[311], ys[311]); end
        checks++; if (xs[465] !== 8'd8 || ys[465] !== 7'd70) begin failures++; $display("[TB] FAIL t3 F p3: got (%0d,%0d), expected (8,70)", xs[465], ys[465]); end
        for (int p = 0; p < 10; p++) begin
            checks++; if (cs[p] !== 3'b111) begin failures++; $display("[TB] FAIL t3 row0 label c p%0d: got %0b, expected 111", p, cs[p]); end
            checks++; if (cs[154+p] !== 3'b111) begin failures++; $display("[TB] FAIL t3 row1 label c p%0d: got %0b, expected 111", p, cs[154+p]); end
            checks++; if (cs[462+p] !== 3'b111) begin failures++; $display("[TB] FAIL t3 row3 label c p%0d: got %0b, expected 111", p, cs[462+p]); end
        end
    endtask

    task automatic test_snapshot();
        int extra;
        busA.pattern = '0;
        busA.pattern[1*16+3] = 1'b1;
        busA.beat    = 4'd5;
        busA.select  = 2'd0;
        captureFrame(1'b1);
        checks++; if (nPlots !== 616) begin failures++; $display("[TB] FAIL t4 plots: got %0d, expected 616", nPlots); end
        checks++; if (cs[195] !== 3'b001) begin failures++; $display("[TB] FAIL t4 on c: got %0b, expected 001", cs[195]); end
        checks++; if (cs[186] !== 3'b111) begin failures++; $display("[TB] FAIL t4 off c: got %0b, expected 111", cs[186]); end
        checks++; if (cs[191] !== 3'b000) begin failures++; $display("[TB] FAIL t4 col3 border c: got %0b, expected 000", cs[191]); end
        checks++; if (cs[209] !== 3'b110) begin failures++; $display("[TB] FAIL t4 col5 border c: got %0b, expected 110", cs[209]); end
        checks++; if (cs[154] !== 3'b111) begin failures++; $display("[TB] FAIL t4 row1 label c: got %0b, expected 111", cs[154]); end
        extra = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (busA.plot || busA.busy) extra++;
        end
        checks++; if (extra !== 0) begin failures++; $display("[TB] FAIL t4 second frame: got %0d active cycles, expected 0", extra); end
    endtask

    task automatic test_reset_midframe();
        int cnt;
        busA.pattern = '0;
        busA.beat    = 4'd0;
        busA.select  = 2'd0;
        cnt = 0;
        busA.start = 1'b1;
        @(negedge clk);
        busA.start = 1'b0;
        for (int k = 0; k < 2000 && cnt < 300; k++) begin
            if (busA.plot) cnt++;
            if (cnt < 300) @(negedge clk);
        end
        checks++; if (cnt !== 300) begin failures++; $display("[TB] FAIL t5 reached plot 300: got %0d, expected 300", cnt); end
        resetA = 1'b1;
        #1;
        checks++; if (busA.plot !== 1'b0) begin failures++; $display("[TB] FAIL t5 plot on reset: got %0b, expected 0", busA.plot); end
        checks++; if (busA.busy !== 1'b0) begin failures++; $display("[TB] FAIL t5 busy on reset: got %0b, expected 0", busA.busy); end
        checks++; if (busA.xOut !== 8'd0 || busA.cOut !== 3'd0) begin failures++; $display("[TB] FAIL t5 outputs on reset: got x=%0d c=%0b, expected 0 0", busA.xOut, busA.cOut); end
        @(negedge clk);
        resetA = 1'b0;
        @(negedge clk);
        captureFrame(1'b0);
        checks++; if (nPlots !== 616) begin failures++; $display("[TB] FAIL t5 plots after reset: got %0d, expected 616", nPlots); end
        checks++; if (doneAt !== 617) begin failures++; $display("[TB] FAIL t5 doneAt after reset: got %0d, expected 617", doneAt); end
        checks++; if (xs[0] !== 8'd6 || cs[0] !== 3'b100) begin failures++; $display("[TB] FAIL t5 first pixel: got x=%0d c=%0b, expected x=6 c=100", xs[0], cs[0]); end
    endtask

    task automatic test_autorun();
        int frame;
        int plots0;
        int plots1;
        int doneT0;
        int doneT1;
        int idleGap;
        logic [2:0] f2c15;
        frame   = 0;
        plots0  = 0;
        plots1  = 0;
        doneT0  = -1;
        doneT1  = -1;
        idleGap = 0;
        f2c15   = 3'bxxx;
        busB.start   = 1'b0;
        busB.pattern = 16'h0001;
        busB.beat    = 3'd2;
        busB.select  = 1'b1;
        busB.xOrigin = 8'd250;
        busB.yOrigin = 7'd120;
        busB.autoRun = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 1500; k++) begin
            if (k == 5) busB.pattern = 16'h0000;
            if (busB.plot) begin
                if (frame == 0) begin
                    xs[plots0] = busB.xOut;
                    ys[plots0] = busB.yOut;
                    cs[plots0] = busB.cOut;
                    plots0++;
                end else begin
                    if (plots1 == 15) f2c15 = busB.cOut;
                    plots1++;
                end
            end
            if (frame == 1 && !busB.busy) idleGap++;
            if (busB.done) begin
                if (frame == 0) begin
                    doneT0 = k;
                    frame  = 1;
                end else begin
                    doneT1 = k;
                    busB.autoRun = 1'b0;
                    break;
                end
            end
            @(negedge clk);
        end
        busB.autoRun = 1'b0;
        checks++; if (plots0 !== 276) begin failures++; $display("[TB] FAIL t6 frame1 plots: got %0d, expected 276", plots0); end
        checks++; if (plots1 !== 276) begin failures++; $display("[TB] FAIL t6 frame2 plots: got %0d, expected 276", plots1); end
        checks++; if (doneT0 !== 277) begin failures++; $display("[TB] FAIL t6 first done: got %0d, expected 277", doneT0); end
        checks++; if (doneT1 - doneT0 !== 278) begin failures++; $display("[TB] FAIL t6 done spacing: got %0d, expected 278", doneT1 - doneT0); end
        checks++; if (idleGap !== 1) begin failures++; $display("[TB] FAIL t6 idle gap: got %0d, expected 1", idleGap); end
        checks++; if (xs[0] !== 8'd6 || ys[0] !== 7'd120 || cs[0] !== 3'b111) begin failures++; $display("[TB] FAIL t6 row0 label: got (%0d,%0d,%0b), expected (6,120,111)", xs[0], ys[0], cs[0]); end
        checks++; if (xs[15] !== 8'd251 || ys[15] !== 7'd121 || cs[15] !== 3'b001) begin failures++; $display("[TB] FAIL t6 interior 1,1: got (%0d,%0d,%0b), expected (251,121,001)", xs[15], ys[15], cs[15]); end
        checks++; if (cs[20] !== 3'b001) begin failures++; $display("[TB] FAIL t6 interior 2,2 c: got %0b, expected 001", cs[20]); end
        checks++; if (cs[14] !== 3'b000 || cs[17] !== 3'b000) begin failures++; $display("[TB] FAIL t6 side borders: got %0b %0b, expected 000 000", cs[14], cs[17]); end
        checks++; if (xs[26] !== 8'd2 || ys[26] !== 7'd120 || cs[26] !== 3'b000) begin failures++; $display("[TB] FAIL t6 x wrap: got (%0d,%0d,%0b), expected (2,120,000)", xs[26], ys[26], cs[26]); end
        checks++; if (xs[42] !== 8'd10 || cs[42] !== 3'b110) begin failures++; $display("[TB] FAIL t6 beat col: got x=%0d c=%0b, expected x=10 c=110", xs[42], cs[42]); end
        checks++; if (xs[138] !== 8'd6 || ys[138] !== 7'd12 || cs[138] !== 3'b100) begin failures++; $display("[TB] FAIL t6 y wrap label: got (%0d,%0d,%0b), expected (6,12,100)", xs[138], ys[138], cs[138]); end
        checks++; if (f2c15 !== 3'b111) begin failures++; $display("[TB] FAIL t6 fresh snapshot: got %0b, expected 111", f2c15); end
        repeat (5) @(negedge clk);
        checks++; if (busB.busy !== 1'b0 || busB.plot !== 1'b0) begin failures++; $display("[TB] FAIL t6 stop: got busy=%0b plot=%0b, expected 0 0", busB.busy, busB.plot); end
    endtask

    // Test sequence and summary.
    initial begin
        checks       = 0;
        failures     = 0;
        busA.start   = 1'b0;
        busA.autoRun = 1'b0;
        busA.xOrigin = '0;
        busA.yOrigin = '0;
        busA.pattern = '0;
        busA.beat    = '0;
        busA.select  = '0;
        busB.start   = 1'b0;
        busB.autoRun = 1'b0;
        busB.xOrigin = '0;
        busB.yOrigin = '0;
        busB.pattern = '0;
        busB.beat    = '0;
        busB.select  = '0;
        resetA       = 1'b1;
        resetB       = 1'b1;
        @(negedge clk);
        test_reset();
        test_first_frame();
        test_pattern_colors();
        test_select_highlight();
        test_snapshot();
        test_reset_midframe();
        test_autorun();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
